mem_req_queue: RTL and testbench

Request buffer sitting directly upstream of the single-port `memory` block. It accepts read/write requests from a producer (test driver or bus master), queues them in a small FIFO, and issues them in order on the memory's valid/ready/wr_rd/addr/wdata interface. It returns read data to the producer on a response port.

---
 rtl/mem_req_queue.sv | 147 ++++++++++++++
 tb/tb_mem_req_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_queue.sv
// In-order request queue in front of a single-port memory: buffers producer requests and returns read data.
// Optional macro MEM_REQ_QUEUE_STATS_EN adds saturating write/read handshake counters.
module mem_req_queue #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr_rd,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_wr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_REQ_QUEUE_STATS_EN
  ,
  output logic [15:0]           stat_wr_cnt,
  output logic [15:0]           stat_rd_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state_q, state_d;
  req_t             fifo_q [FIFO_DEPTH];
  req_t             push_entry;
  req_t             head_q, head_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_inc;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, rd_done;
  logic             cap_valid_q;
  logic [DATA_WIDTH-1:0] cap_data_q;

  assign push_entry = '{wr_rd: req_wr_rd, addr: req_addr, wdata: req_wdata};
  assign push       = req_valid && req_ready;
  assign pop        = mem_valid && mem_ready;
  assign rd_done    = pop && !head_q.wr_rd;
  assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
  assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

  // Memory-side outputs come straight from the registered head; head_q is zero outside ISSUE.
  assign mem_valid = (state_q == ISSUE);
  assign mem_wr_rd = head_q.wr_rd;
  assign mem_addr  = head_q.addr;
  assign mem_wdata = head_q.wdata;

  // Queue storage; no reset needed since occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  // Pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      req_ready <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_inc;
      count_q   <= count_d;
      req_ready <= (count_d != CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
    end
  end

  // Next head: when the only entry pops while a push lands, the new head bypasses storage.
  always_comb begin
    state_d = state_q;
    head_d  = '0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = ISSUE;
          head_d  = fifo_q[rd_ptr_q];
        end
      end
      ISSUE: begin
        if (!mem_ready) begin
          head_d = head_q;
        end else if (count_d != '0) begin
          head_d = (count_q == CNT_W'(1)) ? push_entry : fifo_q[rd_ptr_inc];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-stage read return: capture on the handshake edge, present one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      cap_valid_q <= rd_done;
      if (rd_done) cap_data_q <= mem_rdata;
      rsp_valid   <= cap_valid_q;
      if (cap_valid_q) rsp_rdata <= cap_data_q;
    end
  end

`ifdef MEM_REQ_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
    end else begin
      if (pop && head_q.wr_rd && (stat_wr_cnt != 16'hFFFF)) stat_wr_cnt <= stat_wr_cnt + 16'd1;
      if (rd_done && (stat_rd_cnt != 16'hFFFF))             stat_rd_cnt <= stat_rd_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue with a simple behavioural memory on the mem_* side.
module tb_mem_req_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr_rd = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       mem_valid;
  logic       mem_ready = 1'b0;
  logic       mem_wr_rd;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
`ifdef MEM_REQ_QUEUE_STATS_EN
  logic [15:0] stat_wr_cnt, stat_rd_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  tb_mem [16];
  logic        mem_init = 1'b0;
  logic        prev_mv = 1'b0;
  logic [12:0] hs_q[$];
  int          hs_edge_q[$];
  logic [7:0]  rsp_q[$];
  int          rsp_cyc_q[$];
  int          rise_q[$];

  mem_req_queue dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr_rd(req_wr_rd),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr_rd(mem_wr_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_REQ_QUEUE_STATS_EN
    , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = tb_mem[mem_addr];

  // Behavioural memory: preloaded with 8'hE0|addr, written on write handshakes.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= 8'hE0 | 8'(i);
      mem_init <= 1'b1;
    end else if (mem_valid && mem_ready && mem_wr_rd) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end

  // Monitor: handshakes (with the edge they complete on), responses, mem_valid rises.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_valid && mem_ready) begin
        hs_q.push_back({mem_wr_rd, mem_addr, mem_wdata});
        hs_edge_q.push_back(cyc + 1);
      end
      if (rsp_valid) begin
        rsp_q.push_back(rsp_rdata);
        rsp_cyc_q.push_back(cyc);
      end
      if (mem_valid && !prev_mv) rise_q.push_back(cyc);
    end
    prev_mv <= mem_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge, with push_edge set.
  task automatic send(input logic wr, input logic [3:0] a, input logic [7:0] d, output int push_edge);
    int n = 0;
    req_valid = 1'b1; req_wr_rd = wr; req_addr = a; req_wdata = d;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 0, 1);
    @(negedge clk);
    push_edge = cyc;
    req_valid = 1'b0;
  endtask

  initial begin
    int pe, pe2, hb, rb, gaps, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_wr_rd", mem_wr_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write A5 to 3 then read it back, memory always ready
    mem_ready = 1'b1;
    hb = hs_q.size(); rb = rsp_q.size();
    send(1'b1, 4'd3, 8'hA5, pe);
    send(1'b0, 4'd3, 8'h00, pe2);
    repeat (8) @(negedge clk);
    check("t1_rise_edge", rise_q[0], pe + 1);
    check("t1_wr_hs_edge", hs_edge_q[hb], pe + 2);
    check("t1_hs_count", hs_q.size() - hb, 2);
    check("t1_rsp_count", rsp_q.size() - rb, 1);
    check("t1_rsp_data", rsp_q[rb], 8'hA5);
    check("t1_rsp_timing", rsp_cyc_q[rb], hs_edge_q[hb + 1] + 1);

    // Fill beyond depth with memory stalled
    mem_ready = 1'b0;
    hb = hs_q.size(); rb = rsp_q.size();
    for (int i = 0; i < 4; i++) send(1'b1, 4'(8 + i), 8'(8'h10 + i), pe);
    check("t2_full_ready", req_ready, 0);
    fork
      send(1'b0, 4'd8, 8'h00, pe);
      begin
        repeat (3) @(negedge clk);
        check("t2_wait_ready", req_ready, 0);
        check("t2_wait_addr", mem_addr, 8);
        mem_ready = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    check("t2_hs_count", hs_q.size() - hb, 5);
    check("t2_hs0", hs_q[hb + 0], {1'b1, 4'd8, 8'h10});
    check("t2_hs1", hs_q[hb + 1], {1'b1, 4'd9, 8'h11});
    check("t2_hs2", hs_q[hb + 2], {1'b1, 4'd10, 8'h12});
    check("t2_hs3", hs_q[hb + 3], {1'b1, 4'd11, 8'h13});
    check("t2_hs4", hs_q[hb + 4], {1'b0, 4'd8, 8'h00});
    check("t2_rsp_data", rsp_q[rb], 8'h10);

    // Read of 7 held in ISSUE for 3 stalled cycles
    mem_ready = 1'b0;
    rb = rsp_q.size();
    send(1'b0, 4'd7, 8'h00, pe);
    n = 0;
    while (!mem_valid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("t3_issue_timeout", 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_valid", mem_valid, 1);
      check("t3_hold_addr", mem_addr, 7);
      check("t3_hold_wr_rd", mem_wr_rd, 0);
      check("t3_no_rsp", rsp_valid, 0);
    end
    mem_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("t3_rsp_count", rsp_q.size() - rb, 1);
    check("t3_rsp_data", rsp_q[rb], 8'hE7);

    // Sweep: 16 writes then 16 reads, one per cycle
    hb = hs_q.size(); rb = rsp_q.size();
    for (int i = 0; i < 16; i++) send(1'b1, 4'(i), 8'(i) ^ 8'h3C, pe);
    for (int i = 0; i < 16; i++) send(1'b0, 4'(i), 8'h00, pe);
    repeat (8) @(negedge clk);
    check("t4_hs_count", hs_q.size() - hb, 32);
    gaps = 0;
    for (int i = 1; i < 32; i++) if (hs_edge_q[hb + i] != hs_edge_q[hb + i - 1] + 1) gaps++;
    check("t4_gaps", gaps, 0);
    check("t4_rsp_count", rsp_q.size() - rb, 16);
    for (int i = 0; i < 16; i++) check("t4_rsp_data", rsp_q[rb + i], 8'(i) ^ 8'h3C);

    // Reset with one request issuing and three queued
    mem_ready = 1'b0;
    send(1'b0, 4'd1, 8'h00, pe);
    send(1'b1, 4'd3, 8'hFF, pe);
    send(1'b0, 4'd2, 8'h00, pe);
    send(1'b0, 4'd4, 8'h00, pe);
    check("t5_pre_issue", mem_valid, 1);
    hb = hs_q.size(); rb = rsp_q.size();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_mem_valid", mem_valid, 0);
    check("t5_req_ready", req_ready, 1);
    check("t5_rsp_valid", rsp_valid, 0);
    mem_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_no_hs", hs_q.size() - hb, 0);
    check("t5_no_rsp", rsp_q.size() - rb, 0);
    send(1'b0, 4'd3, 8'h00, pe);
    repeat (6) @(negedge clk);
    check("t5_new_rsp_count", rsp_q.size() - rb, 1);
    check("t5_new_rsp_data", rsp_q[rb], 8'h3F);

`ifdef MEM_REQ_QUEUE_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("st_rst_wr", stat_wr_cnt, 0);
    check("st_rst_rd", stat_rd_cnt, 0);
    for (int i = 0; i < 10; i++) send(1'b1, 4'(i), 8'(i), pe);
    for (int i = 0; i < 6; i++) send(1'b0, 4'(i), 8'h00, pe);
    repeat (8) @(negedge clk);
    check("st_wr_cnt", stat_wr_cnt, 10);
    check("st_rd_cnt", stat_rd_cnt, 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
